// File: rtl/dm_pkg.sv
// Shared definitions for the byte-enabled data memory: access size codes,
// the clear/run state type and the load lane-select/extend helper.
// No ports; imported by data_mem_be and dm_lane_merge.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } dm_state_t;

  // Pick the addressed lane out of a word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lo,
                                              input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      SZ_WORD: r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Store lane merge: overlays right-aligned store data onto the old word.
// Latency: combinational.  Backpressure: none (pure function of inputs).
// Ports: old_word (current word), wdata (store data), size (access size),
//        addr_lo (byte offset), merged (word to write back).
module dm_lane_merge
  import dm_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: begin
        case (addr_lo)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      SZ_WORD: merged = wdata;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/data_mem_be.sv
// Byte-enabled data memory with post-reset clear and sign/zero-extended loads.
// Latency: loads combinational; stores commit at the next rising clk edge.
// Backpressure: busy=1 during the clear; requests then are ignored, not queued.
// Ports: clk, reset (sync, active-high); req_valid/req_we/req_size/req_signed,
//        addr, wdata, pc (request); rdata, busy, misalign (responses).
// Build option: define DM_WRITE_LOG_EN to print one line per committed store.
module data_mem_be
  import dm_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        misalign
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  dm_state_t             state_q;
  dm_state_t             state_d;
  logic [DEPTH_LOG2-1:0] clr_cnt;
  logic                  clr_last;
  logic [31:0]           mem [DEPTH];

  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] widx;
  logic [31:0]           old_word;
  logic [31:0]           merged;
  logic                  store_commit;

  // Upper offset bits are dropped so the address space wraps onto the array.
  assign off      = addr - BASE_ADDR;
  assign widx     = off[DEPTH_LOG2+1:2];
  assign old_word = mem[widx];
  assign clr_last = (clr_cnt == {DEPTH_LOG2{1'b1}});

  logic unused_off;
  assign unused_off = ^{off[31:DEPTH_LOG2+2], off[1:0]};

  assign misalign = req_valid & ((req_size == SZ_RSVD) |
                                 ((req_size == SZ_HALF) & addr[0]) |
                                 ((req_size == SZ_WORD) & (addr[1:0] != 2'b00)));

  // A reset cycle never commits a store.
  assign store_commit = req_valid & req_we & ~misalign & ~busy & ~reset;

  // Loads read the pre-edge array, so a same-cycle store is not visible yet.
  assign rdata = (req_valid & ~misalign & ~busy)
               ? load_extend(old_word, req_size, addr[1:0], req_signed)
               : 32'h0;

  dm_lane_merge u_merge (
    .old_word (old_word),
    .wdata    (wdata),
    .size     (req_size),
    .addr_lo  (addr[1:0]),
    .merged   (merged)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_CLEAR;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_last) state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == ST_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (reset)     clr_cnt <= '0;
    else if (busy) clr_cnt <= clr_cnt + 1'b1;
  end

  // Array has no reset of its own; the clear sweep zeroes it word by word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy)              mem[clr_cnt] <= 32'h0;
      else if (store_commit) mem[widx]    <= merged;
    end
  end

`ifdef DM_WRITE_LOG_EN
  always_ff @(posedge clk) begin
    if (store_commit)
      $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_data_mem_be.sv
module tb_data_mem_be;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] addr, wdata, pc;
  logic [31:0] rdata;
  logic        busy, misalign;

  int checks = 0;
  int errors = 0;

  data_mem_be dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .addr       (addr),
    .wdata      (wdata),
    .pc         (pc),
    .rdata      (rdata),
    .busy       (busy),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mdl [1024];
  int          busy_left = 0;
  bit          mdl_ok = 0;

  function automatic int nbits_of(input logic [1:0] sz);
    return (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
  endfunction

  function automatic int shift_of(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd0) ? 8 * int'(a % 4) : (sz == 2'd1) ? 16 * int'((a / 2) % 2) : 0;
  endfunction

  function automatic bit mdl_mis(input logic v, input logic [1:0] sz, input logic [31:0] a);
    return v && (sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0));
  endfunction

  function automatic logic [31:0] mdl_mask(input int nb);
    logic [31:0] one;
    one = 32'h1;
    return (nb >= 32) ? 32'hFFFF_FFFF : ((one << nb) - 32'h1);
  endfunction

  function automatic logic [31:0] mdl_rdata(input logic v, input logic [1:0] sz,
                                            input logic sg, input logic [31:0] a);
    logic [31:0] w, m, val;
    int nb;
    if (!v || busy_left > 0 || mdl_mis(v, sz, a)) return 32'h0;
    w   = mdl[(a / 4) % 1024];
    nb  = nbits_of(sz);
    m   = mdl_mask(nb);
    val = (w >> shift_of(sz, a)) & m;
    if (sg && nb < 32 && val[nb-1]) val = val | ~m;
    return val;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mdl[i] = 32'h0;
      busy_left = 1024;
      mdl_ok    = 1;
    end else if (mdl_ok) begin
      if (busy_left > 0) begin
        busy_left = busy_left - 1;
      end else if (req_valid && req_we && !mdl_mis(req_valid, req_size, addr)) begin
        logic [31:0] m;
        int sh, idx;
        sh  = shift_of(req_size, addr);
        m   = mdl_mask(nbits_of(req_size)) << sh;
        idx = int'((addr / 4) % 1024);
        mdl[idx] = (mdl[idx] & ~m) | ((wdata << sh) & m);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("busy", {31'b0, busy}, {31'b0, busy_left > 0});
      chk("misalign", {31'b0, misalign}, {31'b0, mdl_mis(req_valid, req_size, addr)});
      chk("rdata", rdata, mdl_rdata(req_valid, req_size, req_signed, addr));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    req_valid = 0; req_we = 0; req_size = 2'd2; req_signed = 0;
    addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic cyc(input logic v, input logic we, input logic [1:0] sz,
                     input logic sg, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    req_valid = v; req_we = we; req_size = sz; req_signed = sg;
    addr = a; wdata = wd;
    @(negedge clk);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 5000) begin
      n = n + 1;
      if (n == 1) idle();
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    reset = 1'b1;
    pc    = 32'h0000_3008;
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    // store presented during the clear must be dropped
    req_valid = 1; req_we = 1; req_size = 2'd2; addr = 32'h50; wdata = 32'hCAFE_F00D;
    count_busy(n);
    chk("busy_len_first", n, 32'd1024);

    cyc(1, 0, 2'd2, 0, 32'h3FC, 0);          chk("load_3fc_zero", rdata, 32'h0);
    cyc(1, 0, 2'd2, 0, 32'h50, 0);           chk("dropped_store", rdata, 32'h0);

    cyc(1, 1, 2'd2, 0, 32'h10, 32'h1122_3344);
    cyc(1, 1, 2'd0, 0, 32'h12, 32'h0000_00AB); chk("same_cycle_old", rdata, 32'h22);
    cyc(1, 0, 2'd2, 0, 32'h10, 0);           chk("byte_merge", rdata, 32'h11AB_3344);

    cyc(1, 1, 2'd2, 0, 32'h1010, 32'h0000_0099);
    cyc(1, 0, 2'd2, 0, 32'h10, 0);           chk("addr_wrap", rdata, 32'h0000_0099);

    cyc(1, 1, 2'd2, 0, 32'h20, 32'h0000_80F0);
    cyc(1, 0, 2'd1, 1, 32'h20, 0);           chk("half_signed", rdata, 32'hFFFF_80F0);
    cyc(1, 0, 2'd1, 0, 32'h20, 0);           chk("half_unsigned", rdata, 32'h0000_80F0);
    cyc(1, 0, 2'd0, 1, 32'h20, 0);           chk("byte_signed", rdata, 32'hFFFF_FFF0);
    cyc(1, 0, 2'd0, 1, 32'h21, 0);           chk("byte1_signed", rdata, 32'hFFFF_FF80);
    cyc(1, 0, 2'd0, 0, 32'h21, 0);           chk("byte1_unsigned", rdata, 32'h0000_0080);

    cyc(1, 1, 2'd2, 0, 32'h22, 32'hFFFF_FFFF);
    chk("mis_word_flag", {31'b0, misalign}, 32'd1);
    chk("mis_word_rdata", rdata, 32'h0);
    cyc(1, 0, 2'd2, 0, 32'h20, 0);           chk("mis_unchanged", rdata, 32'h0000_80F0);
    cyc(1, 0, 2'd3, 0, 32'h20, 0);           chk("size3_flag", {31'b0, misalign}, 32'd1);
    cyc(1, 1, 2'd1, 0, 32'h23, 32'h1234);    chk("mis_half_flag", {31'b0, misalign}, 32'd1);
    cyc(1, 1, 2'd1, 0, 32'h22, 32'h0000_BEEF);
    cyc(1, 0, 2'd2, 0, 32'h20, 0);           chk("half_merge", rdata, 32'hBEEF_80F0);
    cyc(0, 0, 2'd2, 0, 32'h21, 0);
    chk("novalid_rdata", rdata, 32'h0);
    chk("novalid_mis", {31'b0, misalign}, 32'd0);

    // reset, then reset again 500 cycles into the clear
    @(posedge clk); #1; idle(); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    repeat (500) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    count_busy(n);
    chk("busy_len_restart", n, 32'd1024);
    cyc(1, 0, 2'd2, 0, 32'h10, 0);           chk("cleared_10", rdata, 32'h0);
    cyc(1, 0, 2'd2, 0, 32'h20, 0);           chk("cleared_20", rdata, 32'h0);

    cyc(1, 1, 2'd2, 0, 32'h40, 32'hDEAD_BEEF);
    cyc(1, 0, 2'd2, 0, 32'h40, 0);           chk("store_40", rdata, 32'hDEAD_BEEF);
    cyc(0, 0, 2'd2, 0, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors = errors + 1;
    $display("FAIL timeout: simulation did not complete within bound");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_be.md
DATA_MEM_BE -- requirements
Module: data_mem_be

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of 32-bit words (1024 words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address that maps to word 0.
REQ-003 SHALL have port clk, input, 1, the clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1, meaning an access is presented this cycle.
REQ-006 SHALL have port req_we, input, 1, meaning 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2, meaning 0 = byte, 1 = half, 2 = word; 3 is reserved.
REQ-008 SHALL have port req_signed, input, 1, meaning sign-extend loads (1) or zero-extend them (0).
REQ-009 SHALL have port addr, input, 32, the byte address.
REQ-010 SHALL have port wdata, input, 32, store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port pc, input, 32, the PC of the issuing instruction, used only for the write log.
REQ-012 SHALL have port rdata, output, 32, the extended load result.
REQ-013 SHALL have port busy, output, 1, high while the memory clear is in progress.
REQ-014 SHALL have port misalign, output, 1, an alignment/size fault on the current request.

Function
REQ-015 SHALL use a two-state FSM: CLEAR and RUN.
REQ-016 In CLEAR: SHALL write zero to word clr_cnt each cycle and increment clr_cnt; SHALL move to RUN on the cycle clr_cnt = 2^DEPTH_LOG2-1; clearing takes 2^DEPTH_LOG2 cycles.
REQ-017 busy SHALL be 1 exactly when the state is CLEAR.
REQ-018 Word index SHALL be (addr-BASE_ADDR)[DEPTH_LOG2+1:2]; upper bits SHALL be ignored (address wraps).
REQ-019 misalign SHALL be combinational: req_valid & (size=3 | (size=1 & addr[0]) | (size=2 & addr[1:0]!=0)).
REQ-020 Loads SHALL be combinational (zero latency): select byte lane addr[1:0] or half lane addr[1], then extend per req_signed.
REQ-021 A store SHALL commit at the rising edge only if req_valid & req_we & !misalign & !busy.
REQ-022 A committed store SHALL update only the addressed byte lanes; the other bytes of the word SHALL be kept.
REQ-023 rdata SHALL be 0 when busy=1, misalign=1, or req_valid=0.
REQ-024 A load in the cycle after a store to the same word SHALL return the new data; a load in the same cycle SHALL return the old data.
REQ-025 Stores presented while busy=1 SHALL be dropped silently; no queueing.

Reset
REQ-026 reset SHALL force state CLEAR, set clr_cnt=0 and busy=1 on the next edge, and suppress any store in that cycle.
REQ-027 A reset during CLEAR SHALL restart the clear from word 0.
REQ-028 After reset deasserts, busy SHALL stay high for exactly 2^DEPTH_LOG2 cycles.

Configuration
REQ-029 With DM_WRITE_LOG_EN defined: every committed store SHALL print "%d@%h: *%h <= %h" using $time, pc, the word-aligned addr, and the merged 32-bit word.
REQ-030 Without DM_WRITE_LOG_EN: no display statements SHALL exist and the behaviour SHALL be otherwise identical.

Structure
REQ-031 Package dm_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state typedef.
REQ-032 Sub-module dm_lane_merge SHALL take the old word, wdata, size and addr[1:0], and produce the merged word (combinational).

Verification
REQ-033 Reset, then count cycles with busy=1 -> 1024 cycles; afterwards a load of word at 0x3FC returns 0.
REQ-034 Store word 0x11223344 at 0x10, then store byte 0xAB at 0x12 -> word load at 0x10 returns 0x11AB3344.
REQ-035 With word 0x0000_80F0 at 0x20: half load at 0x20 with signed=1 -> 0xFFFF80F0; with signed=0 -> 0x000080F0; signed byte load at 0x20 -> 0xFFFFFFF0.
REQ-036 Word store at 0x22 -> misalign=1, memory unchanged, rdata=0; size=3 request -> misalign=1.
REQ-037 Store issued during busy is dropped; reset asserted at clear cycle 500 -> busy then lasts 1024 more cycles and the earlier data reads as 0.
REQ-038 With DM_WRITE_LOG_EN, word store 0xDEADBEEF at 0x40 with pc=0x3008 -> log shows 00003008, 00000040, deadbeef.
